// File: rtl/mips_exc_ctrl.sv
// mips_exc_ctrl: M-stage exception/interrupt/eret sequencer (wait for bus, flush, redirect)
//   i_clk, i_reset_n          : clock, async active-low reset
//   i_exc_valid, i_exc_code   : M-stage slot valid and its ExcCode (0 = none)
//   i_int_req, i_eret, i_epc  : masked interrupt, eret in M, current EPC
//   i_mem_busy                : outstanding bus transaction, defers event entry
//   o_take, o_exc_code        : CP0 latch pulse and code (0 for interrupt)
//   o_exl_clr                 : EXL clear pulse for eret
//   o_flush, o_redirect       : pipeline flush and PC override valid
//   o_target, o_busy          : PC override value, controller not idle
module mips_exc_ctrl #(
  parameter logic [31:0] HANDLER_PC   = 32'h0000_4180,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_exc_valid,
  input  logic [4:0]  i_exc_code,
  input  logic        i_int_req,
  input  logic        i_eret,
  input  logic [31:0] i_epc,
  input  logic        i_mem_busy,
  output logic        o_take,
  output logic [4:0]  o_exc_code,
  output logic        o_flush,
  output logic        o_redirect,
  output logic [31:0] o_target,
  output logic        o_exl_clr,
  output logic        o_busy
);
  localparam logic [1:0] IDLE = 2'd0, WAIT_BUS = 2'd1, FLUSH = 2'd2, REDIRECT = 2'd3;
  localparam logic [2:0] FL = 3'(FLUSH_CYCLES - 1);
  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        eret_q, eret_d;
  logic [4:0]  code_q, code_d;
  logic [31:0] tgt_q, tgt_d;
  logic        exc, ev, ent_flush, flush_d;
  assign exc = i_exc_valid && i_exc_code != 5'd0;
  assign ev = i_int_req || exc || i_eret;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    eret_d = eret_q;
    code_d = code_q;
    tgt_d = tgt_q;
    case (state_q)
      IDLE: if (ev) begin
        state_d = i_mem_busy ? WAIT_BUS : FLUSH;
        cnt_d = FL;
        eret_d = !i_int_req && !exc;
        code_d = (!i_int_req && exc) ? i_exc_code : 5'd0;
        tgt_d = eret_d ? i_epc : HANDLER_PC;
      end
      WAIT_BUS: if (!i_mem_busy) begin
        state_d = FLUSH;
        cnt_d = FL;
      end
      FLUSH: begin
        state_d = (cnt_q == 3'd0) ? REDIRECT : FLUSH;
        cnt_d = (cnt_q == 3'd0) ? cnt_q : cnt_q - 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  // outputs are registered from next-state so they line up with the state they describe
  assign ent_flush = state_d == FLUSH && state_q != FLUSH;
  assign flush_d = state_d == FLUSH || state_d == REDIRECT;
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      eret_q <= 1'b0;
      code_q <= '0;
      tgt_q <= '0;
      o_take <= 1'b0;
      o_exl_clr <= 1'b0;
      o_flush <= 1'b0;
      o_exc_code <= '0;
      o_redirect <= 1'b0;
      o_target <= '0;
      o_busy <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      eret_q <= eret_d;
      code_q <= code_d;
      tgt_q <= tgt_d;
      o_take <= ent_flush && !eret_d;
      o_exl_clr <= ent_flush && eret_d;
      o_flush <= flush_d;
      o_exc_code <= flush_d ? code_d : 5'd0;
      o_redirect <= state_d == REDIRECT;
      o_target <= state_d == REDIRECT ? tgt_d : 32'd0;
      o_busy <= state_d != IDLE;
    end
  end
endmodule

// File: tb/tb_mips_exc_ctrl.sv
// tb_mips_exc_ctrl: randomized + directed check of mips_exc_ctrl against a timeline model
module tb_mips_exc_ctrl;
  localparam logic [31:0] HPC = 32'h0000_4180;
  logic clk = 1'b0, rst_n = 1'b0;
  logic exc_valid = 0, int_req = 0, eret = 0, mem_busy = 0;
  logic [4:0] exc_code = 0;
  logic [31:0] epc = 0;
  logic [1:0] take_w, exl_w, flush_w, redir_w, busy_w;
  logic [4:0] code_w [2];
  logic [31:0] tgt_w [2];
  int checks = 0, failures = 0;
  bit act [2], wt [2], pb [2], er [2];
  int k [2];
  int nf [2] = '{2, 1};
  logic [4:0] mc [2];
  logic [31:0] mt [2];
  always #5 clk = ~clk;
  mips_exc_ctrl #(.HANDLER_PC(HPC), .FLUSH_CYCLES(2)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_exc_valid(exc_valid), .i_exc_code(exc_code),
    .i_int_req(int_req), .i_eret(eret), .i_epc(epc), .i_mem_busy(mem_busy),
    .o_take(take_w[0]), .o_exc_code(code_w[0]), .o_flush(flush_w[0]), .o_redirect(redir_w[0]),
    .o_target(tgt_w[0]), .o_exl_clr(exl_w[0]), .o_busy(busy_w[0]));
  mips_exc_ctrl #(.HANDLER_PC(HPC), .FLUSH_CYCLES(1)) dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_exc_valid(exc_valid), .i_exc_code(exc_code),
    .i_int_req(int_req), .i_eret(eret), .i_epc(epc), .i_mem_busy(mem_busy),
    .o_take(take_w[1]), .o_exc_code(code_w[1]), .o_flush(flush_w[1]), .o_redirect(redir_w[1]),
    .o_target(tgt_w[1]), .o_exl_clr(exl_w[1]), .o_busy(busy_w[1]));
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, a, e, $time);
    end
  endtask
  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      act[i] = 0; wt[i] = 0; pb[i] = 0; k[i] = 0;
    end
  endtask
  // k counts cycles into the flush/redirect timeline: 0..nf-1 flush, nf redirect
  task automatic step(input int i);
    bit ex, ev, start;
    ex = exc_valid && exc_code != 0;
    ev = int_req || ex || eret;
    start = 0;
    if (!pb[i]) begin
      if (ev) begin
        er[i] = !int_req && !ex;
        mc[i] = int_req ? 5'd0 : exc_code;
        mt[i] = er[i] ? epc : HPC;
        if (mem_busy) wt[i] = 1; else start = 1;
      end
    end else if (wt[i]) begin
      if (!mem_busy) begin wt[i] = 0; start = 1; end
    end else if (act[i]) begin
      k[i]++;
      if (k[i] > nf[i]) act[i] = 0;
    end
    if (start) begin act[i] = 1; k[i] = 0; end
    pb[i] = act[i] || wt[i];
  endtask
  task automatic compare(input int i);
    bit red;
    red = act[i] && k[i] == nf[i];
    chk($sformatf("take%0d", i), 32'(take_w[i]), 32'(act[i] && k[i] == 0 && !er[i]));
    chk($sformatf("exl%0d", i), 32'(exl_w[i]), 32'(act[i] && k[i] == 0 && er[i]));
    chk($sformatf("flush%0d", i), 32'(flush_w[i]), 32'(act[i]));
    chk($sformatf("redir%0d", i), 32'(redir_w[i]), 32'(red));
    chk($sformatf("target%0d", i), tgt_w[i], red ? mt[i] : 32'd0);
    chk($sformatf("busy%0d", i), 32'(busy_w[i]), 32'(act[i] || wt[i]));
    if (act[i] && !er[i]) chk($sformatf("code%0d", i), 32'(code_w[i]), 32'(mc[i]));
  endtask
  task automatic cycle();
    @(posedge clk);
    if (rst_n) begin step(0); step(1); end
    #1;
    compare(0);
    compare(1);
  endtask
  task automatic idle_in();
    exc_valid = 0; exc_code = 0; int_req = 0; eret = 0; mem_busy = 0;
  endtask
  task automatic async_reset();
    #2 rst_n = 0;
    model_clear();
    #1;
    chk("rst_flush", 32'(flush_w), 0);
    chk("rst_busy", 32'(busy_w), 0);
  endtask
  initial begin
    model_clear();
    repeat (2) cycle();
    chk("rst_outs", {take_w, exl_w, flush_w, redir_w, busy_w, code_w[0], tgt_w[0]}, 0);
    rst_n = 1;
    exc_valid = 1; exc_code = 5'd4;
    cycle();
    idle_in();
    chk("e_take", 32'(take_w[0]), 1);
    chk("e_code", 32'(code_w[0]), 4);
    chk("e_flush1", 32'(flush_w[0]), 1);
    cycle();
    chk("e_flush2", 32'(flush_w[0]), 1);
    cycle();
    chk("e_redir", 32'(redir_w[0]), 1);
    chk("e_target", tgt_w[0], 32'h4180);
    cycle();
    chk("e_idle", 32'(busy_w[0]), 0);
    eret = 1; epc = 32'h3010;
    cycle();
    idle_in();
    chk("r_exl", 32'(exl_w[0]), 1);
    chk("r_take", 32'(take_w[0]), 0);
    cycle();
    cycle();
    chk("r_target", tgt_w[0], 32'h3010);
    cycle();
    int_req = 1; mem_busy = 1;
    cycle();
    int_req = 0;
    cycle();
    cycle();
    mem_busy = 0;
    chk("i_wait_busy", 32'(busy_w[0]), 1);
    chk("i_wait_take", 32'(take_w[0]), 0);
    cycle();
    chk("i_take", 32'(take_w[0]), 1);
    chk("i_code", 32'(code_w[0]), 0);
    repeat (3) cycle();
    int_req = 1; exc_valid = 1; exc_code = 5'd10; eret = 1;
    cycle();
    idle_in();
    chk("s_take", 32'(take_w[0]), 1);
    chk("s_exl", 32'(exl_w[0]), 0);
    chk("s_code", 32'(code_w[0]), 0);
    repeat (3) cycle();
    exc_valid = 1; exc_code = 5'd7;
    cycle();
    exc_code = 5'd9;
    chk("b_take1", 32'(take_w[1]), 1);
    cycle();
    chk("b_redir1", 32'(redir_w[1]), 1);
    cycle();
    idle_in();
    chk("b_idle1", 32'(busy_w[1]), 0);
    repeat (4) cycle();
    exc_valid = 1; exc_code = 5'd12;
    cycle();
    idle_in();
    async_reset();
    cycle();
    #2 rst_n = 1;
    repeat (4) cycle();
    for (int n = 0; n < 4000; n++) begin
      int_req = $urandom_range(0, 7) == 0;
      exc_valid = $urandom_range(0, 1) == 1;
      exc_code = $urandom_range(0, 2) == 0 ? 5'd0 : 5'($urandom);
      eret = $urandom_range(0, 5) == 0;
      mem_busy = $urandom_range(0, 2) == 0;
      epc = $urandom;
      if ($urandom_range(0, 199) == 0) begin
        async_reset();
        cycle();
        #2 rst_n = 1;
      end else cycle();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
